// File: rtl/mio_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : mio_bus_responder
// Brief    : Responder for the CPU memory/IO handshake; routes accesses to
//            data RAM, LED/switch GPIO or a free-running 32-bit counter.
// Revision : 1.0 - initial release
// ============================================================================
module mio_bus_responder #(
    parameter int RAM_WAIT = 2,
    parameter int RAM_AW   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CPU_MIO,
    input  logic              mem_w,
    input  logic [31:0]       Addr_bus,
    input  logic [31:0]       Data_out,
    output logic [31:0]       Data_in,
    output logic              MIO_ready,
    output logic              bus_err,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
    input  logic [15:0]       SW,
    output logic [15:0]       LED_out,
    output logic [31:0]       counter_out
);

    localparam logic [29:0] c_GPIO_WORD = 30'h3800_0000;
    localparam logic [29:0] c_CNT_WORD  = 30'h3C00_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_wait_cnt;
    logic        w_accept;
    logic        w_last;
    logic        w_is_ram;
    logic        w_is_gpio;
    logic        w_is_cnt;
    logic        w_is_err;
    logic        w_unused;

    // Byte-lane bits are not part of the decode.
    assign w_unused  = &{1'b0, Addr_bus[1:0]};

    assign w_is_ram  = (Addr_bus[31:RAM_AW+2] == '0);
    assign w_is_gpio = (Addr_bus[31:2] == c_GPIO_WORD);
    assign w_is_cnt  = (Addr_bus[31:2] == c_CNT_WORD);
    assign w_is_err  = !(w_is_ram || w_is_gpio || w_is_cnt);
    assign w_accept  = (r_state == S_IDLE) && CPU_MIO;
    assign w_last    = (r_wait_cnt == 4'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (CPU_MIO) w_next = w_is_ram ? S_WAIT : S_RESP;
            S_WAIT:  if (w_last)  w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Peripheral accesses complete at the accept edge; RAM completes when the
    // wait counter expires. Pulse outputs default low every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt  <= 4'd0;
            Data_in     <= 32'd0;
            MIO_ready   <= 1'b0;
            bus_err     <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_din     <= 32'd0;
            LED_out     <= 16'd0;
            counter_out <= 32'd0;
        end else begin
            counter_out <= counter_out + 32'd1;
            MIO_ready   <= 1'b0;
            bus_err     <= 1'b0;
            ram_we      <= 1'b0;
            if (w_accept) begin
                ram_addr <= Addr_bus[RAM_AW+1:2];
                ram_din  <= Data_out;
                if (w_is_ram) begin
                    r_wait_cnt <= 4'(RAM_WAIT);
                    ram_we     <= mem_w;
                end else begin
                    MIO_ready <= 1'b1;
                    bus_err   <= w_is_err;
                    if (w_is_gpio) begin
                        if (mem_w) LED_out <= Data_out[15:0];
                        else       Data_in <= {16'd0, SW};
                    end else if (w_is_cnt) begin
                        if (mem_w) counter_out <= Data_out;
                        else       Data_in     <= counter_out;
                    end else if (!mem_w) begin
                        Data_in <= 32'd0;
                    end
                end
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
                if (w_last) begin
                    Data_in   <= ram_dout;
                    MIO_ready <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mio_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mio_bus_responder
// Brief    : Scoreboard bench for mio_bus_responder with a behavioural RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mio_bus_responder;

    localparam int RAM_WAIT = 2;
    localparam int RAM_AW   = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              CPU_MIO = 1'b0;
    logic              mem_w = 1'b0;
    logic [31:0]       Addr_bus = '0;
    logic [31:0]       Data_out = '0;
    logic [31:0]       Data_in;
    logic              MIO_ready;
    logic              bus_err;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_din;
    logic [31:0]       ram_dout;
    logic [15:0]       SW = '0;
    logic [15:0]       LED_out;
    logic [31:0]       counter_out;

    mio_bus_responder #(.RAM_WAIT(RAM_WAIT), .RAM_AW(RAM_AW)) dut (
        .clk(clk), .rst(rst), .CPU_MIO(CPU_MIO), .mem_w(mem_w),
        .Addr_bus(Addr_bus), .Data_out(Data_out), .Data_in(Data_in),
        .MIO_ready(MIO_ready), .bus_err(bus_err), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .SW(SW), .LED_out(LED_out), .counter_out(counter_out)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:(1<<RAM_AW)-1];
    assign ram_dout = mem[ram_addr];
    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_din;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        cd;
        int          acc;
        int          lat;
    } exp_t;
    exp_t q[$];

    // Response monitor: pops one expectation per MIO_ready pulse.
    int          we_cnt = 0;
    logic [31:0] we_addr = '0;
    logic [31:0] we_din = '0;
    always @(negedge clk) begin
        exp_t e;
        if (ram_we) begin
            we_cnt++;
            we_addr = 32'(ram_addr);
            we_din  = ram_din;
        end
        if (bus_err && !MIO_ready) chk("lone_err", 32'(bus_err), 32'd0);
        if (MIO_ready) begin
            if (q.size() == 0) begin
                chk("unexp_rdy", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                chk("bus_err", 32'(bus_err), 32'(e.err));
                if (e.cd) chk("rdata", Data_in, e.data);
            end
        end
    end

    logic [31:0] cnt_d = '0;
    int          cnt_a = 0;

    task automatic wait_ready();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!MIO_ready && n < 40);
        if (!MIO_ready) chk("timeout", 32'd0, 32'd1);
    endtask

    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] ed, input logic ee, input int lat,
                       input logic cd, input logic cnt_rd, output int acc);
        exp_t e;
        @(negedge clk);
        CPU_MIO  = 1'b1;
        mem_w    = w;
        Addr_bus = a;
        Data_out = d;
        acc = cyc + 1;
        e.data = cnt_rd ? (cnt_d + 32'(acc - 1 - cnt_a)) : ed;
        e.err  = ee;
        e.cd   = cd;
        e.acc  = acc;
        e.lat  = lat;
        q.push_back(e);
        wait_ready();
        CPU_MIO  = 1'b0;
        mem_w    = 1'b0;
        Addr_bus = $urandom;
        Data_out = $urandom;
    endtask

    initial begin
        int acc;
        int r1;
        exp_t e;
        for (int i = 0; i < (1 << RAM_AW); i++) mem[i] = '0;

        repeat (3) @(negedge clk);
        chk("rst_ready",   32'(MIO_ready), 32'd0);
        chk("rst_err",     32'(bus_err), 32'd0);
        chk("rst_we",      32'(ram_we), 32'd0);
        chk("rst_datain",  Data_in, 32'd0);
        chk("rst_led",     32'(LED_out), 32'd0);
        chk("rst_cnt",     counter_out, 32'd0);
        chk("rst_raddr",   32'(ram_addr), 32'd0);
        chk("rst_rdin",    ram_din, 32'd0);
        rst = 1'b0;

        // RAM write, then read back
        txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'd0, 1'b0, RAM_WAIT + 1, 1'b0, 1'b0, acc);
        chk("we_count", 32'(we_cnt), 32'd1);
        chk("we_addr",  we_addr, 32'd4);
        chk("we_din",   we_din, 32'hDEAD_BEEF);
        txn(1'b0, 32'h0000_0013, 32'h0, 32'hDEAD_BEEF, 1'b0, RAM_WAIT + 1, 1'b1, 1'b0, acc);
        chk("we_rd", 32'(we_cnt), 32'd1);

        // GPIO
        txn(1'b1, 32'hE000_0000, 32'h0001_A5A5, 32'd0, 1'b0, 1, 1'b0, 1'b0, acc);
        chk("led", 32'(LED_out), 32'h0000_A5A5);
        chk("we_gpio", 32'(we_cnt), 32'd1);
        SW = 16'h1234;
        txn(1'b0, 32'hE000_0002, 32'h0, 32'h0000_1234, 1'b0, 1, 1'b1, 1'b0, acc);

        // Counter load and wrap
        txn(1'b1, 32'hF000_0000, 32'hFFFF_FFFE, 32'd0, 1'b0, 1, 1'b0, 1'b0, acc);
        cnt_d = 32'hFFFF_FFFE;
        cnt_a = acc;
        chk("cnt_load", counter_out, 32'hFFFF_FFFE);
        @(negedge clk);
        chk("cnt_inc", counter_out, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("cnt_wrap", counter_out, 32'h0000_0000);
        repeat (5) @(negedge clk);
        txn(1'b0, 32'hF000_0000, 32'h0, 32'd0, 1'b0, 1, 1'b1, 1'b1, acc);

        // Unmapped accesses
        txn(1'b0, 32'h8000_0000, 32'h0, 32'd0, 1'b1, 1, 1'b1, 1'b0, acc);
        chk("err_led", 32'(LED_out), 32'h0000_A5A5);
        chk("err_we", 32'(we_cnt), 32'd1);
        chk("err_cnt", counter_out, cnt_d + 32'(cyc - cnt_a));
        txn(1'b1, 32'h0000_1000, 32'h5555_5555, 32'd0, 1'b1, 1, 1'b0, 1'b0, acc);
        chk("errw_we", 32'(we_cnt), 32'd1);
        chk("errw_led", 32'(LED_out), 32'h0000_A5A5);

        // Top word of the RAM window
        txn(1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 32'd0, 1'b0, RAM_WAIT + 1, 1'b0, 1'b0, acc);
        chk("top_we_addr", we_addr, 32'h3FF);
        txn(1'b0, 32'h0000_0FFC, 32'h0, 32'hCAFE_F00D, 1'b0, RAM_WAIT + 1, 1'b1, 1'b0, acc);

        // Back-to-back GPIO writes with CPU_MIO held
        @(negedge clk);
        CPU_MIO  = 1'b1;
        mem_w    = 1'b1;
        Addr_bus = 32'hE000_0000;
        Data_out = 32'h0000_1111;
        e = '{32'd0, 1'b0, 1'b0, cyc + 1, 1};
        q.push_back(e);
        wait_ready();
        r1 = cyc;
        Data_out = 32'h0000_2222;
        e = '{32'd0, 1'b0, 1'b0, cyc + 2, 1};
        q.push_back(e);
        wait_ready();
        chk("b2b_gap", 32'(cyc - r1), 32'd2);
        CPU_MIO = 1'b0;
        mem_w   = 1'b0;
        @(negedge clk);
        chk("b2b_led", 32'(LED_out), 32'h0000_2222);

        // Reset during a RAM read's wait phase
        @(negedge clk);
        CPU_MIO  = 1'b1;
        mem_w    = 1'b0;
        Addr_bus = 32'h0000_0010;
        @(negedge clk);
        CPU_MIO = 1'b0;
        rst     = 1'b1;
        #1;
        chk("arst_ready",  32'(MIO_ready), 32'd0);
        chk("arst_datain", Data_in, 32'd0);
        chk("arst_led",    32'(LED_out), 32'd0);
        chk("arst_cnt",    counter_out, 32'd0);
        chk("arst_raddr",  32'(ram_addr), 32'd0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        txn(1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, RAM_WAIT + 1, 1'b1, 1'b0, acc);

        repeat (5) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mio_bus_responder.md
Name: mio_bus_responder

Overview:
- Responder side of the CPU memory/IO handshake. The CPU control unit drives CPU_MIO/mem_w and waits on MIO_ready; this block serves those requests.
- Decodes the bus address and routes each access to external data RAM, the LED/switch GPIO port, or a 32-bit counter.
- Returns read data and a one-cycle MIO_ready pulse after a fixed, region-dependent latency.
- Sits between the single-cycle CPU and its data RAM/peripherals.

Parameters:
- RAM_WAIT, 2, cycles spent in the RAM wait state (legal range 1..15).
- RAM_AW, 10, RAM word-address width; RAM region covers 4·2^RAM_AW bytes from 0x00000000.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- CPU_MIO  in  1  request, level; held by CPU until MIO_ready.
- mem_w  in  1  1 = write, 0 = read; valid with CPU_MIO.
- Addr_bus  in  32  byte address; bits [1:0] ignored.
- Data_out  in  32  CPU write data.
- Data_in  out  32  read data to CPU; valid while MIO_ready=1.
- MIO_ready  out  1  one-cycle completion pulse.
- bus_err  out  1  one-cycle pulse, coincident with MIO_ready, on an unmapped address.
- ram_we  out  1  RAM write enable.
- ram_addr  out  RAM_AW  RAM word address.
- ram_din  out  32  RAM write data.
- ram_dout  in  32  RAM read data, combinational from ram_addr.
- SW  in  16  switch inputs.
- LED_out  out  16  LED register.
- counter_out  out  32  current counter value.

Behaviour:
- Reset (async, rst=1): state IDLE; MIO_ready, bus_err, ram_we, Data_in, ram_addr, ram_din, LED_out, counter_out and wait counter all = 0.
- Reset mid-transaction aborts it; no MIO_ready is issued.
- Address map, decoded on the latched address:
  - Addr[31:RAM_AW+2]==0 → RAM.
  - 0xE0000000 → GPIO. Write sets LED_out=Data_out[15:0]. Read returns {16'b0, SW}.
  - 0xF0000000 → counter. Write loads Data_out. Read returns counter_out.
  - Anything else → error. Write is discarded; read returns 0; bus_err=1.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If CPU_MIO=1 at the clock edge, latch Addr_bus, Data_out and mem_w.
  - ram_addr ← Addr_bus[RAM_AW+1:2]; ram_din ← Data_out.
  - RAM region → WAIT with wait counter = RAM_WAIT. All other regions → RESP.
  - GPIO/counter writes and reads are performed at this same edge.
- WAIT:
  - ram_we=1 only in the first WAIT cycle, and only for a write; otherwise 0.
  - Wait counter decrements each cycle. At the edge where it reaches 1: go to RESP and capture Data_in ← ram_dout (captured value is don't-care for writes).
- RESP:
  - MIO_ready=1 (and bus_err if applicable) for exactly one cycle, then IDLE.
  - Data_in holds its value until the next capture.
- Latency, accept edge to the cycle MIO_ready is high:
  - GPIO, counter, error: 1 cycle.
  - RAM: RAM_WAIT+1 cycles.
- Back-to-back: if CPU_MIO is still high in the IDLE cycle after RESP, it is a new transaction. There is one idle turnaround cycle minimum.
- Inputs are ignored outside IDLE. Changes to CPU_MIO, Addr_bus or Data_out mid-transaction have no effect.
- Counter:
  - Increments by 1 every cycle; wraps 0xFFFFFFFF → 0.
  - A counter write loads Data_out at the accept edge, replacing that cycle's increment.
  - A counter read returns the value before that edge's increment.
- ram_we is never asserted for non-RAM regions or for reads.

Test Plan:
- RAM write then read, RAM_WAIT=2:
  - Write Addr 0x00000010, data 0xDEADBEEF → ram_we high for exactly 1 cycle with ram_addr=4, ram_din=0xDEADBEEF; MIO_ready 3 cycles after accept.
  - Read same address with RAM model returning 0xDEADBEEF → Data_in=0xDEADBEEF while MIO_ready=1.
- GPIO:
  - Write 0xE0000000 with 0x0001A5A5 → LED_out=0xA5A5; MIO_ready 1 cycle after accept; ram_we stays 0.
  - Read with SW=0x1234 → Data_in=0x00001234.
- Counter:
  - Write 0xF0000000 with 0xFFFFFFFE → counter_out=0xFFFFFFFE, then 0xFFFFFFFF, then 0x00000000 (wrap).
  - A later read returns the value present at the accept edge.
- Unmapped read at 0x80000000 → Data_in=0; MIO_ready and bus_err both high for the same single cycle; no RAM/LED/counter change.
- Reset mid-RAM-read: assert rst during WAIT → all outputs 0 immediately; no MIO_ready pulse; a fresh request after reset completes normally.
- Back-to-back: hold CPU_MIO high across two GPIO writes (0x1111, then 0x2222) → two separate MIO_ready pulses separated by exactly 1 idle cycle; final LED_out=0x2222.
